// File: rtl/xlr8_io_fifo_pkg.sv
// xlr8_io_fifo_pkg: CTRL/STATUS bit positions and the CTRL register type
// shared by the receive FIFO top level and its storage.
package xlr8_io_fifo_pkg;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IEN   = 1;
    localparam int CTRL_FLUSH = 2;
    localparam int CTRL_OVF   = 5;
    localparam int CTRL_EMPTY = 6;
    localparam int CTRL_FULL  = 7;

    typedef struct packed {
        logic ovf;
        logic ien;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/xlr8_io_fifo_mem.sv
// xlr8_io_fifo_mem: circular byte storage with wrapping pointers and occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module xlr8_io_fifo_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; a flushed or reset FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/xlr8_io_fifo.sv
// xlr8_io_fifo: receive-side byte FIFO on the AVR IO bus; fabric pushes via
// valid/ready, the CPU pops by reading DATA, and PEND drives one xlr8_irq bit.
module xlr8_io_fifo
    import xlr8_io_fifo_pkg::*;
#(
    parameter logic [5:0] CTRL_ADR = 6'h20,
    parameter logic [5:0] DATA_ADR = 6'h21,
    parameter logic [5:0] CNT_ADR  = 6'h22,
    parameter int         DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] io_arb_mux_adr,
    input  logic       io_arb_mux_iore,
    input  logic       io_arb_mux_iowe,
    input  logic [7:0] io_arb_mux_dbusout,
    output logic [7:0] stgi_xf_io_slv_dbusout,
    output logic       stgi_xf_io_slv_out_en,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       irq,
    input  logic       irq_ack
);

    localparam int AW = $clog2(DEPTH);

    ctrl_t       ctrl;
    logic        pend;
    logic [7:0]  head;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic [7:0]  status;
    logic        ctrl_hit, data_hit, cnt_hit;
    logic        ctrl_wr, flush, push, pop;
    logic        ovf_set, ovf_clr, pend_set, pend_clr;

    assign ctrl_hit = io_arb_mux_adr == CTRL_ADR;
    assign data_hit = io_arb_mux_adr == DATA_ADR;
    assign cnt_hit  = io_arb_mux_adr == CNT_ADR;

    assign ctrl_wr  = io_arb_mux_iowe && ctrl_hit;
    assign flush    = ctrl_wr && io_arb_mux_dbusout[CTRL_FLUSH];

    // Flush discards a same-cycle push or pop and does not count as overflow.
    assign in_ready = ctrl.en && !full;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = io_arb_mux_iore && data_hit && !empty && !flush;
    assign ovf_set  = in_valid && ctrl.en && full && !flush;
    assign ovf_clr  = ctrl_wr && io_arb_mux_dbusout[CTRL_OVF];
    assign pend_set = push && empty && ctrl.ien;
    assign pend_clr = irq_ack || flush || (ctrl_wr && !io_arb_mux_dbusout[CTRL_IEN]);

    xlr8_io_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= '0;
            pend <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl.en  <= io_arb_mux_dbusout[CTRL_EN];
                ctrl.ien <= io_arb_mux_dbusout[CTRL_IEN];
            end
            ctrl.ovf <= ovf_set || (ctrl.ovf && !ovf_clr);
            pend     <= pend_set || (pend && !pend_clr);
        end
    end

    assign irq = pend;

    always_comb begin
        status                  = '0;
        status[CTRL_FULL]       = full;
        status[CTRL_EMPTY]      = empty;
        status[CTRL_OVF]        = ctrl.ovf;
        status[CTRL_IEN]        = ctrl.ien;
        status[CTRL_EN]         = ctrl.en;
        stgi_xf_io_slv_out_en   = io_arb_mux_iore && (ctrl_hit || data_hit || cnt_hit);
        stgi_xf_io_slv_dbusout  = !stgi_xf_io_slv_out_en ? 8'h00 :
                                  ctrl_hit ? status :
                                  data_hit ? (empty ? 8'h00 : head) :
                                  8'(count);
    end

endmodule
